// File: rtl/bounce_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : bounce_sequencer                                                 |
// | Ping-pong counter between latched limits for a commanded number of        |
// | endpoint arrivals. Define BOUNCE_SEQ_DWELL_EN for endpoint dwell support. |
// | Rev    : 1.0  initial release                                             |
// +---------------------------------------------------------------------------+
module bounce_sequencer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_lo,
  input  logic [W-1:0] cmd_hi,
  input  logic [3:0]   cmd_passes,
  input  logic [3:0]   cmd_dwell,
  input  logic         abort,
  output logic [W-1:0] s,
  output logic         dir,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0]   c_st_idle   = 2'd0;
  localparam logic [1:0]   c_st_run    = 2'd1;
  localparam logic [1:0]   c_st_dwell  = 2'd2;
  localparam logic [1:0]   c_st_finish = 2'd3;
  localparam logic [W-1:0] c_one       = W'(1);

  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;
  logic [W-1:0] r_s;
  logic [W-1:0] r_lo;
  logic [W-1:0] r_hi;
  logic [W-1:0] w_step;
  logic         r_dir;
  logic [3:0]   r_passes;
  logic [3:0]   r_arrivals;
  logic [3:0]   w_arr_inc;
  logic         w_accept;
  logic         w_arrive;
  logic         w_final;
  logic         w_dwell_go;
  logic         w_dwell_last;

`ifdef BOUNCE_SEQ_DWELL_EN
  logic [3:0]   r_dwell;
  logic [3:0]   r_dwell_cnt;
  assign w_dwell_go   = (r_dwell != 4'd0);
  assign w_dwell_last = (r_dwell_cnt <= 4'd1);
`else
  logic         w_unused_dwell;
  assign w_unused_dwell = ^cmd_dwell;
  assign w_dwell_go     = 1'b0;
  assign w_dwell_last   = 1'b1;
`endif

  assign w_accept  = cmd_valid && (r_state == c_st_idle) && !abort;
  assign w_step    = r_dir ? (r_s - c_one) : (r_s + c_one);
  // An arrival is the step that lands on the limit in the direction of travel.
  assign w_arrive  = r_dir ? (w_step == r_lo) : (w_step == r_hi);
  assign w_arr_inc = (r_arrivals == 4'd15) ? 4'd15 : (r_arrivals + 4'd1);
  assign w_final   = (r_passes != 4'd0) && (w_arr_inc == r_passes);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_accept) begin
          w_state_nxt = (cmd_lo < cmd_hi) ? c_st_run : c_st_finish;
        end
      end
      c_st_run: begin
        if (abort) begin
          w_state_nxt = c_st_idle;
        end else if (w_arrive) begin
          if (w_final) begin
            w_state_nxt = c_st_finish;
          end else if (w_dwell_go) begin
            w_state_nxt = c_st_dwell;
          end
        end
      end
      c_st_dwell: begin
        if (abort) begin
          w_state_nxt = c_st_idle;
        end else if (w_dwell_last) begin
          w_state_nxt = c_st_run;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s        <= '0;
      r_dir      <= 1'b0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_passes   <= '0;
      r_arrivals <= '0;
`ifdef BOUNCE_SEQ_DWELL_EN
      r_dwell     <= '0;
      r_dwell_cnt <= '0;
`endif
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_s        <= cmd_lo;
            r_dir      <= 1'b0;
            r_arrivals <= 4'd0;
            r_lo       <= cmd_lo;
            r_hi       <= cmd_hi;
            r_passes   <= cmd_passes;
`ifdef BOUNCE_SEQ_DWELL_EN
            r_dwell    <= cmd_dwell;
`endif
          end
        end
        c_st_run: begin
          if (!abort) begin
            r_s <= w_step;
            if (w_arrive) begin
              r_arrivals <= w_arr_inc;
              // The final arrival keeps its direction so the finish view is unambiguous.
              if (!w_final) begin
                r_dir <= ~r_dir;
              end
`ifdef BOUNCE_SEQ_DWELL_EN
              r_dwell_cnt <= r_dwell;
`endif
            end
          end
        end
`ifdef BOUNCE_SEQ_DWELL_EN
        c_st_dwell: begin
          if (!abort) begin
            r_dwell_cnt <= r_dwell_cnt - 4'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd_ready = (r_state == c_st_idle) && !abort;
    busy      = (r_state != c_st_idle);
    done      = (r_state == c_st_finish);
    s         = r_s;
    dir       = r_dir;
  end

endmodule
`default_nettype wire

// File: tb/tb_bounce_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : tb_bounce_sequencer                                              |
// | Self-checking bench: trajectory model plus directed and random commands.  |
// | Rev    : 1.0  initial release                                             |
// +---------------------------------------------------------------------------+
module tb_bounce_sequencer;

  localparam int W = 4;
`ifdef BOUNCE_SEQ_DWELL_EN
  localparam bit DWELL_EN = 1'b1;
`else
  localparam bit DWELL_EN = 1'b0;
`endif

  logic         clk        = 1'b0;
  logic         rst        = 1'b1;
  logic         cmd_valid  = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_lo     = '0;
  logic [W-1:0] cmd_hi     = '0;
  logic [3:0]   cmd_passes = '0;
  logic [3:0]   cmd_dwell  = '0;
  logic         abort      = 1'b0;
  logic [W-1:0] s;
  logic         dir;
  logic         busy;
  logic         done;

  bounce_sequencer #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_lo     (cmd_lo),
    .cmd_hi     (cmd_hi),
    .cmd_passes (cmd_passes),
    .cmd_dwell  (cmd_dwell),
    .abort      (abort),
    .s          (s),
    .dir        (dir),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: on acceptance the whole expected output trajectory is planned up front.
  typedef struct packed {
    logic [W-1:0] s;
    logic         dir;
    logic         done;
  } step_t;

  step_t        traj[$];
  logic [W-1:0] m_s    = '0;
  logic         m_dir  = 1'b0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;

  function automatic step_t mk(input int v, input int d, input bit fin);
    step_t e;
    e.s    = W'(v);
    e.dir  = d[0];
    e.done = fin;
    return e;
  endfunction

  task automatic plan(input logic [W-1:0] lo, input logic [W-1:0] hi,
                      input logic [3:0] passes, input logic [3:0] dwell);
    int v;
    int d;
    int arr;
    int hold;
    traj.delete();
    if (lo >= hi) begin
      traj.push_back(mk(int'(lo), 0, 1'b1));
      return;
    end
    v   = int'(lo);
    d   = 0;
    arr = 0;
    traj.push_back(mk(v, d, 1'b0));
    while (traj.size() < 1000) begin
      v = (d != 0) ? v - 1 : v + 1;
      if (v == ((d != 0) ? int'(lo) : int'(hi))) begin
        arr = (arr < 15) ? arr + 1 : 15;
        if (passes != 4'd0 && arr == int'(passes)) begin
          traj.push_back(mk(v, d, 1'b1));
          break;
        end
        d    = 1 - d;
        hold = DWELL_EN ? int'(dwell) : 0;
        for (int k = 0; k <= hold; k++) traj.push_back(mk(v, d, 1'b0));
      end else begin
        traj.push_back(mk(v, d, 1'b0));
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      traj.delete();
      m_s    <= '0;
      m_dir  <= 1'b0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else if (m_busy) begin
      if ((abort && !m_done) || traj.size() == 0) begin
        traj.delete();
        m_busy <= 1'b0;
        m_done <= 1'b0;
      end else begin
        m_s    <= traj[0].s;
        m_dir  <= traj[0].dir;
        m_done <= traj[0].done;
        void'(traj.pop_front());
      end
    end else if (cmd_valid && !abort) begin
      plan(cmd_lo, cmd_hi, cmd_passes, cmd_dwell);
      m_busy <= 1'b1;
      m_s    <= traj[0].s;
      m_dir  <= traj[0].dir;
      m_done <= traj[0].done;
      void'(traj.pop_front());
    end
  end

  always @(negedge clk) begin
    check("s", s, m_s);
    check("dir", dir, m_dir);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("cmd_ready", cmd_ready, !m_busy && !abort);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int lo, input int hi, input int passes, input int dwell);
    cmd_valid  = 1'b1;
    cmd_lo     = W'(lo);
    cmd_hi     = W'(hi);
    cmd_passes = 4'(passes);
    cmd_dwell  = 4'(dwell);
    tick();
    cmd_valid  = 1'b0;
    cmd_lo     = W'($urandom);
    cmd_hi     = W'($urandom);
    cmd_passes = 4'($urandom);
    cmd_dwell  = 4'($urandom);
  endtask

  int exp_a[7] = '{2, 3, 4, 5, 4, 3, 2};

  initial begin : stim
    int c15;
    int c0;
    int n;
    bit got;

    #1 rst = 1'b0;
    #12;
    check("rst_s", s, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dir", dir, 0);
    check("rst_ready", cmd_ready, 1);
    @(posedge clk);
    #2 rst = 1'b1;

    // Simple two-pass bounce.
    tick();
    send(2, 5, 2, 0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("A_s", s, exp_a[i]);
      check("A_done", done, (i == 6));
    end
    @(negedge clk);
    check("A_busy_drop", busy, 0);

    // Degenerate command clears a leftover down direction.
    tick();
    check("C_dir_before", dir, 1);
    send(7, 7, 3, 0);
    @(negedge clk);
    check("C_s", s, 7);
    check("C_done", done, 1);
    check("C_dir", dir, 0);
    @(negedge clk);
    check("C_done_low", done, 0);
    check("C_busy_low", busy, 0);

    // Full-range run with endpoint dwell.
    tick();
    send(0, 15, 3, 2);
    c15 = 0;
    c0  = 0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (done) begin
        got = 1'b1;
        check("B_final_s", s, 15);
      end else begin
        if (s == 4'd15) c15++;
        if (s == 4'd0)  c0++;
      end
    end
    check("B_done_seen", got, 1);
    check("B_hold15", c15, DWELL_EN ? 3 : 1);
    check("B_hold0", c0, DWELL_EN ? 4 : 2);
    check("B_len", n, DWELL_EN ? 50 : 46);

    // Endless run stopped by abort; abort also blocks a new offer.
    tick();
    send(1, 3, 0, 0);
    repeat (10) @(posedge clk);
    #2;
    abort     = 1'b1;
    cmd_valid = 1'b1;
    cmd_lo    = 4'd0;
    cmd_hi    = 4'd5;
    @(negedge clk);
    check("D_s_pre", s, 3);
    check("D_ready_busy", cmd_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("D_ready", cmd_ready, 0);
      check("D_busy", busy, 0);
      check("D_done", done, 0);
      check("D_s_held", s, 3);
      check("D_dir_held", dir, 1);
    end
    tick();
    abort     = 1'b0;
    cmd_valid = 1'b0;

    // Asynchronous reset in the middle of an endpoint dwell.
    tick();
    send(0, 3, 0, 5);
    repeat (4) @(posedge clk);
    #2;
    check("E_dir_pre", dir, 1);
    rst = 1'b0;
    #1;
    check("E_s", s, 0);
    check("E_busy", busy, 0);
    check("E_dir", dir, 0);
    check("E_done", done, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    send(4, 9, 1, 0);
    @(negedge clk);
    check("E_accept_busy", busy, 1);
    check("E_accept_s", s, 4);
    got = 1'b0;
    n   = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
    end
    check("E_done_seen", got, 1);
    check("E_done_s", s, 9);

    // Random commands, aborts, mid-command field changes and resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      rst        = 1'b1;
      cmd_valid  = ($urandom_range(0, 2) != 0);
      cmd_lo     = W'($urandom);
      cmd_hi     = W'($urandom);
      cmd_passes = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 5));
      cmd_dwell  = 4'($urandom_range(0, 3));
      abort      = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 599) == 0) rst = 1'b0;
    end
    tick();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    abort     = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
